// File: rtl/param_reg_file.sv
// Register file with NR general and NT temporary registers, a broadcast write port that applies
// dec/inc/load/clear to every enabled register, and two registered read ports with optional bypass.
module param_reg_file #(
    parameter int WIDTH  = 8,
    parameter int NR     = 4,
    parameter int NT     = 4,
    parameter int BYPASS = 1,
    parameter int SELW   = $clog2(NR + NT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       fun_sel,
    input  logic [NR-1:0]    r_sel,
    input  logic [NT-1:0]    t_sel,
    input  logic [SELW-1:0]  o1_sel,
    input  logic [SELW-1:0]  o2_sel,
    input  logic             o1_en,
    input  logic             o2_en,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2
);

    localparam int N = NR + NT;

    typedef enum logic [1:0] {
        FUN_DEC   = 2'b00,
        FUN_INC   = 2'b01,
        FUN_LOAD  = 2'b10,
        FUN_CLEAR = 2'b11
    } fun_e;

    // Storage index 0..NT-1 holds T1..T{NT}, NT..N-1 holds R1..R{NR}.
    logic [WIDTH-1:0] regs [N];
    logic [WIDTH-1:0] nxt  [N];
    logic [N-1:0]     wen;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Enable vectors are MSB-first (MSB = T1 / R1), so they are reversed onto the storage index.
    always_comb begin
        wen = '0;
        for (int k = 0; k < NT; k++) begin
            wen[k] = t_sel[NT-1-k];
        end
        for (int k = 0; k < NR; k++) begin
            wen[NT+k] = r_sel[NR-1-k];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            nxt[i] = regs[i];
            if (wen[i]) begin
                case (fun_e'(fun_sel))
                    FUN_DEC:  nxt[i] = regs[i] - WIDTH'(1);
                    FUN_INC:  nxt[i] = regs[i] + WIDTH'(1);
                    FUN_LOAD: nxt[i] = din;
                    default:  nxt[i] = '0;
                endcase
            end
        end
    end

    // Bypass reads the post-write value; an index past the last register reads as zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(o1_sel) == i) begin
                rd1 = (BYPASS != 0) ? nxt[i] : regs[i];
            end
            if (int'(o2_sel) == i) begin
                rd2 = (BYPASS != 0) ? nxt[i] : regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
            o1 <= '0;
            o2 <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wen[i]) begin
                    regs[i] <= nxt[i];
                end
            end
            if (o1_en) begin
                o1 <= rd1;
            end
            if (o2_en) begin
                o2 <= rd2;
            end
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: default bypass instance, a BYPASS=0 twin on the same
// stimulus, and a 16-bit NR=2/NT=2 instance.
module tb_param_reg_file;

    localparam logic [1:0] DEC = 2'b00, INC = 2'b01, LOAD = 2'b10, CLR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic [1:0]  fun_sel;
    logic [3:0]  r_sel, t_sel;
    logic [2:0]  o1_sel, o2_sel;
    logic        o1_en, o2_en;
    logic [7:0]  o1_b, o2_b, o1_nb, o2_nb;

    logic [15:0] s_din;
    logic [1:0]  s_fun, s_rsel, s_tsel, s_o1sel, s_o2sel;
    logic        s_o1en, s_o2en;
    logic [15:0] s_o1, s_o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_reg_file #(.WIDTH(8), .NR(4), .NT(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .din(din), .fun_sel(fun_sel), .r_sel(r_sel), .t_sel(t_sel),
        .o1_sel(o1_sel), .o2_sel(o2_sel), .o1_en(o1_en), .o2_en(o2_en), .o1(o1_b), .o2(o2_b)
    );

    param_reg_file #(.WIDTH(8), .NR(4), .NT(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .din(din), .fun_sel(fun_sel), .r_sel(r_sel), .t_sel(t_sel),
        .o1_sel(o1_sel), .o2_sel(o2_sel), .o1_en(o1_en), .o2_en(o2_en), .o1(o1_nb), .o2(o2_nb)
    );

    param_reg_file #(.WIDTH(16), .NR(2), .NT(2), .BYPASS(1)) dut_small (
        .clk(clk), .rst(rst), .din(s_din), .fun_sel(s_fun), .r_sel(s_rsel), .t_sel(s_tsel),
        .o1_sel(s_o1sel), .o2_sel(s_o2sel), .o1_en(s_o1en), .o2_en(s_o2en), .o1(s_o1), .o2(s_o2)
    );

    task automatic applyStimulus(input logic r, input logic [1:0] f, input logic [7:0] d,
                                 input logic [3:0] rs, input logic [3:0] ts,
                                 input logic [2:0] s1, input logic e1,
                                 input logic [2:0] s2, input logic e2);
        rst = r; fun_sel = f; din = d; r_sel = rs; t_sel = ts;
        o1_sel = s1; o1_en = e1; o2_sel = s2; o2_en = e2;
        @(posedge clk);
        #1;
    endtask

    task automatic applySmallStimulus(input logic [1:0] f, input logic [15:0] d,
                                      input logic [1:0] rs, input logic [1:0] ts,
                                      input logic [1:0] s1, input logic e1,
                                      input logic [1:0] s2, input logic e2);
        s_fun = f; s_din = d; s_rsel = rs; s_tsel = ts;
        s_o1sel = s1; s_o1en = e1; s_o2sel = s2; s_o2en = e2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; fun_sel = LOAD; din = '0; r_sel = '0; t_sel = '0;
        o1_sel = '0; o2_sel = '0; o1_en = 1'b0; o2_en = 1'b0;
        s_fun = LOAD; s_din = '0; s_rsel = '0; s_tsel = '0;
        s_o1sel = '0; s_o2sel = '0; s_o1en = 1'b0; s_o2en = 1'b0;
        @(posedge clk);
        #1;

        // Some traffic, then a reset that also carries a write and reads.
        applyStimulus(0, LOAD, 8'h77, 4'hF, 4'hF, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, INC,  8'h00, 4'h0, 4'hF, 3'd0, 1, 3'd4, 1);
        checkOutput("pre_rst_o1_b",  {8'h0, o1_b},  16'h0078);
        checkOutput("pre_rst_o1_nb", {8'h0, o1_nb}, 16'h0077);
        applyStimulus(1, LOAD, 8'hFF, 4'hF, 4'hF, 3'd4, 1, 3'd0, 1);
        checkOutput("rst_o1_b",  {8'h0, o1_b},  16'h0);
        checkOutput("rst_o2_b",  {8'h0, o2_b},  16'h0);
        checkOutput("rst_o1_nb", {8'h0, o1_nb}, 16'h0);
        checkOutput("rst_o2_nb", {8'h0, o2_nb}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'(i), 1, 3'(7 - i), 1);
            checkOutput("rst_read_o1", {8'h0, o1_b}, 16'h0);
            checkOutput("rst_read_o2", {8'h0, o2_b}, 16'h0);
        end

        // Load R1 and read it back; R2 stays zero.
        applyStimulus(0, LOAD, 8'hA5, 4'b1000, 4'h0, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd4, 1, 3'd5, 1);
        checkOutput("r1_load_o1", {8'h0, o1_b}, 16'h00A5);
        checkOutput("r2_zero_o2", {8'h0, o2_b}, 16'h0000);

        // Wrap in both directions.
        applyStimulus(0, CLR,  8'h00, 4'h0, 4'hF, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, DEC,  8'h00, 4'h0, 4'b1000, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd0, 1, 3'd1, 1);
        checkOutput("t1_dec_wrap", {8'h0, o1_b}, 16'h00FF);
        checkOutput("t2_untouched", {8'h0, o2_b}, 16'h0000);
        applyStimulus(0, LOAD, 8'hFF, 4'b0001, 4'h0, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd7, 1, 3'd0, 0);
        checkOutput("r4_load_ff", {8'h0, o1_b}, 16'h00FF);
        applyStimulus(0, INC,  8'h00, 4'b0001, 4'h0, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd7, 1, 3'd0, 1);
        checkOutput("r4_inc_wrap", {8'h0, o1_b}, 16'h0000);
        checkOutput("t1_still_ff", {8'h0, o2_b}, 16'h00FF);

        // Same-cycle write and read: bypass versus no bypass.
        applyStimulus(0, LOAD, 8'h10, 4'b0100, 4'h0, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, INC,  8'h00, 4'b0100, 4'h0, 3'd5, 1, 3'd5, 1);
        checkOutput("byp_o1_b",  {8'h0, o1_b},  16'h0011);
        checkOutput("byp_o2_b",  {8'h0, o2_b},  16'h0011);
        checkOutput("byp_o1_nb", {8'h0, o1_nb}, 16'h0010);
        checkOutput("byp_o2_nb", {8'h0, o2_nb}, 16'h0010);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd5, 1, 3'd0, 0);
        checkOutput("after_inc_nb", {8'h0, o1_nb}, 16'h0011);

        // Broadcast load, then read-enable hold.
        applyStimulus(0, LOAD, 8'h3C, 4'hF, 4'hF, 3'd0, 0, 3'd0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'(2 * i), 1, 3'(2 * i + 1), 1);
            checkOutput("bcast_o1", {8'h0, o1_b}, 16'h003C);
            checkOutput("bcast_o2", {8'h0, o2_b}, 16'h003C);
        end
        applyStimulus(0, INC,  8'h00, 4'h0, 4'b1000, 3'd0, 0, 3'd0, 0);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd0, 1, 3'd1, 1);
        checkOutput("t1_inc_o1", {8'h0, o1_b}, 16'h003D);
        checkOutput("t2_hold_o2", {8'h0, o2_b}, 16'h003C);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd5, 0, 3'd0, 1);
        checkOutput("o1_hold_a", {8'h0, o1_b}, 16'h003D);
        checkOutput("o2_t1", {8'h0, o2_b}, 16'h003D);
        applyStimulus(0, LOAD, 8'h99, 4'b0001, 4'h0, 3'd7, 0, 3'd7, 1);
        checkOutput("o1_hold_b", {8'h0, o1_b}, 16'h003D);
        checkOutput("r4_byp_o2_b",  {8'h0, o2_b},  16'h0099);
        checkOutput("r4_byp_o2_nb", {8'h0, o2_nb}, 16'h003C);

        // Reset mid-stream discards the write; the next edge runs from zero.
        applyStimulus(1, LOAD, 8'h55, 4'hF, 4'hF, 3'd0, 1, 3'd7, 1);
        checkOutput("mid_rst_o1", {8'h0, o1_b}, 16'h0);
        checkOutput("mid_rst_o2", {8'h0, o2_b}, 16'h0);
        applyStimulus(0, LOAD, 8'h05, 4'b0010, 4'h0, 3'd6, 1, 3'd0, 1);
        checkOutput("post_rst_o1_b",  {8'h0, o1_b},  16'h0005);
        checkOutput("post_rst_o1_nb", {8'h0, o1_nb}, 16'h0000);
        checkOutput("post_rst_o2_b",  {8'h0, o2_b},  16'h0000);
        applyStimulus(0, LOAD, 8'h00, 4'h0, 4'h0, 3'd0, 0, 3'd0, 0);

        // 16-bit instance with two general and two temporary registers.
        applySmallStimulus(LOAD, 16'hFFFF, 2'b01, 2'b00, 2'd0, 0, 2'd0, 0);
        applySmallStimulus(LOAD, 16'h0000, 2'b00, 2'b00, 2'd3, 1, 2'd2, 1);
        checkOutput("small_r2_ffff", s_o1, 16'hFFFF);
        checkOutput("small_r1_zero", s_o2, 16'h0000);
        applySmallStimulus(INC,  16'h0000, 2'b01, 2'b00, 2'd0, 0, 2'd0, 0);
        applySmallStimulus(LOAD, 16'h0000, 2'b00, 2'b00, 2'd3, 1, 2'd0, 0);
        checkOutput("small_r2_wrap", s_o1, 16'h0000);
        applySmallStimulus(LOAD, 16'h1234, 2'b10, 2'b00, 2'd3, 1, 2'd2, 1);
        checkOutput("small_r1_byp", s_o2, 16'h1234);
        checkOutput("small_r2_keep", s_o1, 16'h0000);
        applySmallStimulus(INC,  16'h0000, 2'b00, 2'b11, 2'd0, 1, 2'd1, 1);
        checkOutput("small_t1_inc", s_o1, 16'h0001);
        checkOutput("small_t2_inc", s_o2, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
